// File: rtl/cmos_spi_init_seq.sv
// rtl/cmos_spi_init_seq.sv - CMOS sensor register-table sequencer driving the SPI_BUS command port
module cmos_spi_init_seq #(
    parameter int NUM_REGS      = 16,
    parameter int SPI_WAIT      = 96,
    parameter int POWERUP_DELAY = 1000,
    parameter bit VERIFY        = 1'b1
) (
    input  logic        clk_input,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  err_index,
    output logic [7:0]  tbl_addr,
    input  logic [24:0] tbl_entry,
    output logic [9:0]  command_address,
    output logic [15:0] data_write,
    output logic        execute_pulse,
    input  logic [15:0] data_read
);

    // A zero delay still costs one cycle so every wait state is left exactly once.
    localparam int PWR_CYC = (POWERUP_DELAY < 1) ? 1 : POWERUP_DELAY;
    localparam int SPI_CYC = (SPI_WAIT < 1) ? 1 : SPI_WAIT;
    localparam int MAX_CYC = (PWR_CYC > SPI_CYC) ? PWR_CYC : SPI_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] SPI_LAST = CW'(SPI_CYC - 1);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);
    localparam logic [8:0]    END_MARK = 9'h1FF;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_LOAD, S_WR, S_WWAIT, S_RD,
        S_RWAIT, S_CHECK, S_NEXT, S_FINISH, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    reg_addr_q, reg_addr_d;
    logic [15:0]   reg_data_q, reg_data_d;
    logic [15:0]   rd_q, rd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [7:0]    err_index_q, err_index_d;
    logic [7:0]    tbl_addr_q, tbl_addr_d;
    logic [9:0]    cmd_q, cmd_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          pulse_q, pulse_d;

    // State and output registers; async reset also kills an in-flight strobe.
    always_ff @(posedge clk_input or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            rd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            tbl_addr_q  <= '0;
            cmd_q       <= '0;
            wdata_q     <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            tbl_addr_q  <= tbl_addr_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            pulse_q     <= pulse_d;
        end
    end

    // Next-state and output logic; the strobe is registered out of WR/RD so the
    // command word has been on the bus for a full cycle before it rises.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        tbl_addr_d  = tbl_addr_q;
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        pulse_d     = 1'b0;

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    tbl_addr_d  = '0;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_PWRUP;
                end
            end
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                reg_addr_d = tbl_entry[24:16];
                reg_data_d = tbl_entry[15:0];
                if (tbl_entry[24:16] == END_MARK) begin
                    state_d = S_FINISH;
                end else begin
                    cmd_d   = {tbl_entry[24:16], 1'b1};
                    wdata_d = tbl_entry[15:0];
                    state_d = S_WR;
                end
            end
            S_WR: begin
                pulse_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WWAIT;
            end
            S_WWAIT: begin
                if (cnt_q == SPI_LAST) begin
                    cnt_d = '0;
                    if (VERIFY) begin
                        cmd_d   = {reg_addr_q, 1'b0};
                        state_d = S_RD;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD: begin
                pulse_d = 1'b1;
                cnt_d   = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (cnt_q == SPI_LAST) begin
                    rd_d    = data_read;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (rd_q == reg_data_q) begin
                    state_d = S_NEXT;
                end else begin
                    error_d     = 1'b1;
                    err_index_d = tbl_addr_q;
                    busy_d      = 1'b0;
                    state_d     = S_FAIL;
                end
            end
            S_NEXT: begin
                if (tbl_addr_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    tbl_addr_d = tbl_addr_q + 8'd1;
                    state_d    = S_LOAD;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign err_index       = err_index_q;
    assign tbl_addr        = tbl_addr_q;
    assign command_address = cmd_q;
    assign data_write      = wdata_q;
    assign execute_pulse   = pulse_q;

endmodule

// File: doc/cmos_spi_init_seq.md
Name: cmos_spi_init_seq

Overview:
- Upstream sequencer that drives the SPI_BUS command interface to configure the CMOS image sensor after power-up.
- Walks an external register table of {address, data} entries. For each entry it issues a write, then an optional read-back, then compares the read data against the table data.
- Outputs connect directly to SPI_BUS `command_address`, `data_write` and `execute_pulse`. Its `data_read` input connects to SPI_BUS `data_read`.
- Reports busy, done and error status to the top-level control logic.

Parameters:
- NUM_REGS, 16: number of table entries to process (1..256).
- SPI_WAIT, 96: clk_input cycles to wait after each execute_pulse before the SPI_BUS transaction is treated as complete.
- POWERUP_DELAY, 1000: clk_input cycles to wait after start before the first transaction (sensor settling).
- VERIFY, 1: 1 = read back and compare every entry; 0 = write only.

Ports:
- clk_input  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run the sequence.
- busy  out  1  high while the sequence is running.
- done  out  1  high once all entries have completed successfully; held until the next start.
- error  out  1  high after a read-back mismatch; held until the next start.
- err_index  out  8  table index of the failing entry.
- tbl_addr  out  8  current table index.
- tbl_entry  in  25  table entry {reg_addr[8:0], reg_data[15:0]}; combinational in tbl_addr, valid one cycle after tbl_addr changes.
- command_address  out  10  to SPI_BUS; format {reg_addr[8:0], rw}, where rw=1 is write and rw=0 is read.
- data_write  out  16  to SPI_BUS write data.
- execute_pulse  out  1  to SPI_BUS; one-cycle start strobe.
- data_read  in  16  from SPI_BUS read data; valid at the end of SPI_WAIT.

Behaviour:
- Clock and reset: one clock (clk_input). Reset is asynchronous, active-low (reset_n).
- Reset values:
  - busy=0, done=0, error=0, err_index=0, tbl_addr=0.
  - command_address=0, data_write=0, execute_pulse=0.
  - State=IDLE, all counters 0.
- IDLE: start=1 -> clear done, error and err_index; set tbl_addr=0 and busy=1; go to PWRUP.
- PWRUP: count POWERUP_DELAY cycles, then go to LOAD.
- LOAD (1 cycle): latch tbl_entry into reg_addr and reg_data.
  - If reg_addr==9'h1FF (end marker), go to FINISH.
  - Otherwise drive command_address={reg_addr,1'b1} and data_write=reg_data, then go to WR.
- WR: execute_pulse=1 for exactly one cycle. The command outputs were already stable in the previous cycle. Go to WWAIT.
- WWAIT: count SPI_WAIT cycles.
  - Then go to RD if VERIFY=1, or to NEXT if VERIFY=0.
  - RD sets command_address={reg_addr,1'b0}; data_write keeps reg_data.
- RD: execute_pulse=1 for one cycle, then go to RWAIT.
- RWAIT: count SPI_WAIT cycles. On the final cycle, sample data_read into rd_reg, then go to CHECK.
- CHECK:
  - rd_reg==reg_data -> go to NEXT.
  - rd_reg!=reg_data -> error=1, err_index=tbl_addr, busy=0, go to FAIL.
- NEXT:
  - If tbl_addr==NUM_REGS-1, go to FINISH.
  - Otherwise increment tbl_addr and go to LOAD.
  - tbl_entry is sampled only in LOAD, which is one cycle after the tbl_addr update.
- FINISH: done=1, busy=0, go to IDLE.
- FAIL: hold outputs. start=1 restarts the sequence exactly as from IDLE.
- start while busy=1 is ignored; no restart and no counter disturbance.
- Outputs stay stable across waits: command_address and data_write never change while an SPI transaction is in flight (pulse cycle through the end of its wait).
- execute_pulse is never high in two consecutive cycles.
- Minimum spacing between pulses is SPI_WAIT+1 cycles.
- Counter widths: wait counters must hold max(POWERUP_DELAY, SPI_WAIT). A delay value of 0 is treated as 1 cycle.
- Index wrap: tbl_addr never exceeds NUM_REGS-1; there is no wrap to 0 within a run.
- Reset asserted mid-transaction: all outputs return to reset values immediately, including execute_pulse=0 asynchronously. No partial sequence is resumed.
- Cycle count per entry:
  - VERIFY=1: 1(LOAD) + 1 + SPI_WAIT + 1 + SPI_WAIT + 1(CHECK) + 1(NEXT).
  - VERIFY=0: 1 + 1 + SPI_WAIT + 1.

Test Plan:
- Reset mid-run: assert reset_n=0 during WWAIT of entry 2 -> execute_pulse, busy and command_address go to 0 asynchronously; after release the block stays in IDLE until start.
- Basic write/verify: NUM_REGS=2, VERIFY=1, SPI_WAIT=8, POWERUP_DELAY=4; table {9'h199,16'hAAAA},{9'h0C5,16'h1234}; data_read model echoes the written data. Required response:
  - Pulses with command_address 10'b1100110011, then 10'b1100110010, then {9'h0C5,1}, then {9'h0C5,0}.
  - done=1 and error=0 at the end; exactly 4 execute_pulse cycles.
- Mismatch: as the basic test, but data_read=16'hAAAB on the first read -> error=1, err_index=0, busy=0, done=0; no further pulses.
- End marker: NUM_REGS=4 with entry 1 reg_addr=9'h1FF -> only entry 0 is processed (2 pulses); done=1 and tbl_addr stops at 1.
- start ignored while busy, and restart from FAIL:
  - A start pulse during PWRUP -> no restart; first pulse still occurs exactly POWERUP_DELAY+2 cycles after the original start.
  - start after FAIL -> error clears and sequence reruns from index 0.
- VERIFY=0, NUM_REGS=3 -> 3 write pulses only, each with rw=1, spaced SPI_WAIT+3 cycles apart; done=1.
